// File: rtl/prio_mode_arbiter.sv
// N-way single-grant arbiter: fixed, round-robin or LFSR-random search start.
// The grant is registered and held until the downstream ack or a requester abort.
module prio_mode_arbiter #(
  parameter int         N         = 4,
  parameter int         IDX_W     = $clog2(N),
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     ack_i,
  output logic             req_o,
  input  logic             ack_o,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [7:0]       lfsr_q
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_BUBBLE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_gnt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] r_last;
  logic [7:0]       r_lfsr;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_win;
  logic             w_found;
  logic             w_arb;
  logic             w_ack;
  logic             w_abort;

  assign w_arb   = (r_state == S_IDLE) && (|req_i);
  assign w_ack   = (r_state == S_GRANT) && ack_o;
  assign w_abort = (r_state == S_GRANT) && !ack_o && !req_i[r_gnt_idx];

  // Search start; mode 3 falls through to fixed priority.
  always_comb begin
    case (mode)
      2'd1:    w_start = (r_last == IDX_W'(N-1)) ? '0 : r_last + 1'b1;
      2'd2:    w_start = IDX_W'(r_lfsr % 8'(N));
      default: w_start = '0;
    endcase
  end

  always_comb begin
    logic [IDX_W:0] w_pos;
    w_pos   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, w_start} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(N)) w_pos = w_pos - (IDX_W+1)'(N);
      if (!w_found && req_i[w_pos[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_pos[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // An ack takes precedence over a simultaneous abort; acks always pass through a bubble.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|req_i) w_next = S_GRANT;
      S_GRANT: begin
        if (ack_o)                  w_next = S_BUBBLE;
        else if (!req_i[r_gnt_idx]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_o = (r_state == S_GRANT);
    ack_i = (req_o && ack_o) ? r_gnt : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_last    <= IDX_W'(N-1);
    end else if (w_arb) begin
      r_gnt     <= N'(1) << w_win;
      r_gnt_idx <= w_win;
    end else if (w_ack || w_abort) begin
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      if (w_ack) r_last <= r_gnt_idx;
    end
  end

  // Free-running Fibonacci LFSR, never gated by arbiter state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign gnt_o   = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign lfsr_q  = r_lfsr;

endmodule
